// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle of the RAM port arbiter: host read/write port 0 and
// data-mover read port 1, with the shared read-data return.
interface ram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 16
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              lock0;
    logic              gnt0;
    logic              rvalid0;

    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              lock1;
    logic              gnt1;
    logic              rvalid1;

    logic [DATA_W-1:0] rdata;

    modport master (
        output req0, we0, addr0, wdata0, lock0, req1, addr1, lock1,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata
    );

    modport slave (
        input  req0, we0, addr0, wdata0, lock0, req1, addr1, lock1,
        output gnt0, rvalid0, gnt1, rvalid1, rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with burst lock sharing one single-port RAM between a
// read/write host port and a read-only data-mover port; returns per-port rvalid.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clock,
    input  logic                rst,
    ram_port_arbiter_if.slave   bus,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_data,
    output logic                ram_wren,
    input  logic [DATA_W-1:0]   ram_q
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT0 = 3'd1,
        GRANT1 = 3'd2,
        LOCK0  = 3'd3,
        LOCK1  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              prio;
    logic              prio_nxt;
    logic              gnt0_c;
    logic              gnt1_c;
    logic [ADDR_W-1:0] addr_hold;
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_port;

    // State and round-robin pointer registers; prio=0 means port 0 wins ties.
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
        end
    end

    // Grant decision: a held lock bypasses arbitration and freezes the pointer.
    always_comb begin
        state_nxt = IDLE;
        prio_nxt  = prio;
        gnt0_c    = 1'b0;
        gnt1_c    = 1'b0;
        if (!rst) begin
            if (state == LOCK0 && bus.req0 && bus.lock0) begin
                gnt0_c    = 1'b1;
                state_nxt = LOCK0;
            end else if (state == LOCK1 && bus.req1 && bus.lock1) begin
                gnt1_c    = 1'b1;
                state_nxt = LOCK1;
            end else begin
                if (bus.req0 && bus.req1) begin
                    gnt0_c   = ~prio;
                    gnt1_c   = prio;
                    prio_nxt = ~prio;
                end else begin
                    gnt0_c = bus.req0;
                    gnt1_c = bus.req1;
                end
                if (gnt0_c) begin
                    state_nxt = bus.lock0 ? LOCK0 : GRANT0;
                end else if (gnt1_c) begin
                    state_nxt = bus.lock1 ? LOCK1 : GRANT1;
                end
            end
        end
    end

    assign bus.gnt0 = gnt0_c;
    assign bus.gnt1 = gnt1_c;

    // The RAM registers its address, so an idle cycle keeps presenting the last one.
    always_comb begin
        if (gnt0_c) begin
            ram_addr = bus.addr0;
        end else if (gnt1_c) begin
            ram_addr = bus.addr1;
        end else if (rst) begin
            ram_addr = '0;
        end else begin
            ram_addr = addr_hold;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            addr_hold <= '0;
        end else if (gnt0_c || gnt1_c) begin
            addr_hold <= ram_addr;
        end
    end

    assign ram_data = bus.wdata0;
    assign ram_wren = gnt0_c & bus.we0;

    // Read-return pipeline tracking {valid, port} alongside the RAM latency.
    always_ff @(posedge clock) begin
        if (rst) begin
            pipe_vld  <= '0;
            pipe_port <= '0;
        end else begin
            pipe_vld[0]  <= (gnt0_c & ~bus.we0) | gnt1_c;
            pipe_port[0] <= gnt1_c;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_port[i] <= pipe_port[i-1];
            end
        end
    end

    // Masked by rst so a read granted just before reset never reports.
    assign bus.rvalid0 = ~rst & pipe_vld[RD_LAT-1] & ~pipe_port[RD_LAT-1];
    assign bus.rvalid1 = ~rst & pipe_vld[RD_LAT-1] &  pipe_port[RD_LAT-1];
    assign bus.rdata   = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed scenarios plus randomized
// two-port traffic, checked against a rule-level model and a shadow memory.
module tb_ram_port_arbiter;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    logic              clock = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clock    (clock),
        .rst      (rst),
        .bus      (bus.slave),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_q    (ram_q)
    );

    always #5 clock = ~clock;

    // Behavioural single-port RAM: registered address, optional output register.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] q1;
    logic [DATA_W-1:0] q2;
    always @(posedge clock) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        q1 <= mem[ram_addr];
        q2 <= q1;
    end
    assign ram_q = (RD_LAT == 2) ? q2 : q1;

    typedef struct {
        logic              in_rst;
        int                g;
        logic              wren;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cyc_t;

    typedef struct {
        int                port;
        logic [DATA_W-1:0] data;
        int                due;
    } rd_t;

    cyc_t gq[$];
    rd_t  rdq[$];
    logic [DATA_W-1:0] shadow [DEPTH];
    int cyc = 0;
    int prio_m = 0;
    int lock_m = -1;
    int vectors = 0;
    int miscompares = 0;
    int timeouts = 0;
    int seen_to = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: decide this cycle's grant from the arbitration rules.
    always @(negedge clock) begin
        int   g;
        cyc_t e;
        rd_t  rd;
        g = -1;
        if (rst) begin
            prio_m = 0;
            lock_m = -1;
            rdq.delete();
        end else if (lock_m == 0 && bus.req0 && bus.lock0) begin
            g = 0;
        end else if (lock_m == 1 && bus.req1 && bus.lock1) begin
            g = 1;
        end else begin
            if (bus.req0 && bus.req1) begin
                g = prio_m;
                prio_m = 1 - prio_m;
            end else if (bus.req0) begin
                g = 0;
            end else if (bus.req1) begin
                g = 1;
            end
            if (g == 0 && bus.lock0) lock_m = 0;
            else if (g == 1 && bus.lock1) lock_m = 1;
            else lock_m = -1;
        end
        e.in_rst = rst;
        e.g      = g;
        e.wren   = (g == 0) && bus.we0;
        e.addr   = (g == 1) ? bus.addr1 : bus.addr0;
        e.wdata  = bus.wdata0;
        gq.push_back(e);
        if (g == 0 && bus.we0) begin
            shadow[bus.addr0] = bus.wdata0;
        end else if (g >= 0) begin
            rd.port = g;
            rd.data = shadow[e.addr];
            rd.due  = cyc + RD_LAT;
            rdq.push_back(rd);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare grants, RAM strobes and read returns against the queues.
    always @(negedge clock) begin
        cyc_t e;
        rd_t  rd;
        #1;
        e = gq.pop_front();
        check("gnt0", 32'(bus.gnt0), 32'(e.g == 0));
        check("gnt1", 32'(bus.gnt1), 32'(e.g == 1));
        check("ram_wren", 32'(ram_wren), 32'(e.wren));
        if (e.g >= 0) check("ram_addr", 32'(ram_addr), 32'(e.addr));
        if (e.wren) check("ram_data", 32'(ram_data), 32'(e.wdata));
        if (e.in_rst) check("ram_addr_rst", 32'(ram_addr), 32'(0));
        if (bus.rvalid0 || bus.rvalid1) begin
            if (rdq.size() == 0 || rdq[0].due != cyc) begin
                check("rvalid_unexpected", 32'({bus.rvalid1, bus.rvalid0}), 32'(0));
            end else begin
                rd = rdq.pop_front();
                check("rvalid_port", 32'({bus.rvalid1, bus.rvalid0}),
                      32'((rd.port == 0) ? 2'b01 : 2'b10));
                check("rdata", 32'(bus.rdata), 32'(rd.data));
            end
        end else if (rdq.size() > 0 && rdq[0].due == cyc) begin
            rd = rdq.pop_front();
            check("rvalid_missing", 32'({bus.rvalid1, bus.rvalid0}),
                  32'((rd.port == 0) ? 2'b01 : 2'b10));
        end
        check("wait_timeout", 32'(timeouts - seen_to), 32'(0));
        seen_to = timeouts;
    end

    task automatic tick(output logic g0, output logic g1);
        @(negedge clock);
        g0 = bus.gnt0;
        g1 = bus.gnt1;
        @(posedge clock);
        #1;
    endtask

    task automatic access0(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic g0, g1, got;
        got = 1'b0;
        bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.lock0 = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            tick(g0, g1);
            got = g0;
        end
        if (!got) timeouts++;
        bus.req0 = 1'b0;
        bus.we0  = 1'b0;
    endtask

    task automatic access1(input logic [ADDR_W-1:0] a);
        logic g0, g1, got;
        got = 1'b0;
        bus.req1 = 1'b1; bus.addr1 = a; bus.lock1 = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            tick(g0, g1);
            got = g1;
        end
        if (!got) timeouts++;
        bus.req1 = 1'b0;
    endtask

    initial begin
        logic g0, g1, pend0, pend1, got;
        int   cnt;

        // Reset held with both ports requesting; port 0 must win first after release.
        rst = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd1; bus.wdata0 = 16'h1234; bus.lock0 = 1'b0;
        bus.req1 = 1'b1; bus.addr1 = 5'd1; bus.lock1 = 1'b0;
        repeat (3) @(posedge clock);
        #1 rst = 1'b0;
        tick(g0, g1);
        bus.req0 = 1'b0; bus.we0 = 1'b0;
        tick(g0, g1);
        bus.req1 = 1'b0;
        tick(g0, g1);

        for (int a = 0; a < int'(DEPTH); a++) access0(1'b1, ADDR_W'(a), DATA_W'($urandom));

        // Write then read back through the data-mover port.
        access0(1'b1, 5'd5, 16'hA5A5);
        access1(5'd5);
        tick(g0, g1);

        // Sustained contention without lock alternates grants.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd0;
        bus.req1 = 1'b1; bus.addr1 = 5'd16;
        for (int n = 0; n < 6; n++) begin
            tick(g0, g1);
            if (g0) bus.addr0 = bus.addr0 + 5'd1;
            if (g1) bus.addr1 = bus.addr1 + 5'd1;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick(g0, g1);

        // Port 1 burst of four locked reads against a waiting port 0.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd10;
        bus.req1 = 1'b1; bus.addr1 = 5'd0; bus.lock1 = 1'b1;
        cnt = 0;
        for (int n = 0; n < 20 && cnt < 4; n++) begin
            tick(g0, g1);
            if (g0) bus.addr0 = bus.addr0 + 5'd1;
            if (g1) begin
                cnt++;
                bus.addr1 = ADDR_W'(cnt);
                if (cnt == 4) bus.lock1 = 1'b0;
            end
        end
        if (cnt < 4) timeouts++;
        for (int n = 0; n < 3; n++) begin
            tick(g0, g1);
            if (g0) bus.addr0 = bus.addr0 + 5'd1;
            if (g1) bus.addr1 = bus.addr1 + 5'd1;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick(g0, g1);

        // Locked read granted, then reset: its return is dropped and lock/prio clear.
        bus.req1 = 1'b1; bus.addr1 = 5'd3; bus.lock1 = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            tick(g0, g1);
            got = g1;
        end
        if (!got) timeouts++;
        rst = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd7;
        tick(g0, g1);
        rst = 1'b0;
        tick(g0, g1);
        bus.req0 = 1'b0;
        tick(g0, g1);
        bus.req1 = 1'b0; bus.lock1 = 1'b0;
        tick(g0, g1);

        // Randomized traffic honouring the hold-until-grant protocol.
        pend0 = 1'b0; pend1 = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            tick(g0, g1);
            rst = ($urandom_range(0, 199) == 0);
            if (g0 || !pend0) begin
                if ($urandom_range(0, 9) < 6) begin
                    pend0 = 1'b1; bus.req0 = 1'b1;
                    bus.we0    = 1'($urandom_range(0, 1));
                    bus.addr0  = ADDR_W'($urandom);
                    bus.wdata0 = DATA_W'($urandom);
                    bus.lock0  = ($urandom_range(0, 9) < 3);
                end else begin
                    pend0 = 1'b0; bus.req0 = 1'b0; bus.lock0 = 1'b0;
                end
            end else if ($urandom_range(0, 29) == 0) begin
                pend0 = 1'b0; bus.req0 = 1'b0; bus.lock0 = 1'b0;
            end
            if (g1 || !pend1) begin
                if ($urandom_range(0, 9) < 6) begin
                    pend1 = 1'b1; bus.req1 = 1'b1;
                    bus.addr1 = ADDR_W'($urandom);
                    bus.lock1 = ($urandom_range(0, 9) < 3);
                end else begin
                    pend1 = 1'b0; bus.req1 = 1'b0; bus.lock1 = 1'b0;
                end
            end else if ($urandom_range(0, 29) == 0) begin
                pend1 = 1'b0; bus.req1 = 1'b0; bus.lock1 = 1'b0;
            end
        end
        rst = 1'b0;
        bus.req0 = 1'b0; bus.lock0 = 1'b0; bus.req1 = 1'b0; bus.lock1 = 1'b0;
        repeat (RD_LAT + 4) tick(g0, g1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
